// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the direct-mapped write-back data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    COMPARE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  localparam int OFFSET_W   = 4;
  localparam int WORD_SEL_W = 2;

  function automatic int index_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/data_cache_if.sv
// CPU load/store port and block-wide memory port of the data cache.
interface data_cache_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128
);
  logic                     cpu_req;
  logic                     cpu_we;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [3:0]               cpu_byte_en;
  logic [31:0]              cpu_wdata;
  logic [31:0]              cpu_rdata;
  logic                     cpu_stall;
  logic                     mem_wr_en;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [BLOCK_WIDTH-1:0]   mem_wdata;
  logic [BLOCK_WIDTH-1:0]   mem_rdata;

  // Cache side
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_byte_en, cpu_wdata, mem_rdata,
    output cpu_rdata, cpu_stall, mem_wr_en, mem_addr, mem_wdata
  );

  // CPU + memory environment side
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_byte_en, cpu_wdata, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_wr_en, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_line_store.sv
// Valid/dirty/tag/data arrays: one combinational read port, one refill-or-store write port.
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int SETS        = 256,
  parameter int TAG_W       = 20,
  parameter int BLOCK_WIDTH = 128,
  parameter int IDX_W       = $clog2(SETS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [IDX_W-1:0]       index,
  output logic                   rd_valid,
  output logic                   rd_dirty,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [BLOCK_WIDTH-1:0] rd_data,
  input  logic                   fill_en,
  input  logic [TAG_W-1:0]       fill_tag,
  input  logic [BLOCK_WIDTH-1:0] fill_data,
  input  logic                   store_en,
  input  logic [WORD_SEL_W-1:0]  store_word,
  input  logic [3:0]             store_be,
  input  logic [31:0]            store_data
);

  logic [SETS-1:0]        valid;
  logic [SETS-1:0]        dirty;
  logic [TAG_W-1:0]       tag_mem   [SETS];
  logic [BLOCK_WIDTH-1:0] line_data [SETS];

  assign rd_valid = valid[index];
  assign rd_dirty = dirty[index];
  assign rd_tag   = tag_mem[index];
  assign rd_data  = line_data[index];

  // Only the status bits are reset; a line is never valid before a full refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
      dirty[index] <= 1'b0;
    end else if (store_en) begin
      dirty[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_mem[index]   <= fill_tag;
      line_data[index] <= fill_data;
    end else if (store_en) begin
      for (int b = 0; b < 4; b++)
        if (store_be[b])
          line_data[index][store_word*32 + b*8 +: 8] <= store_data[b*8 +: 8];
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate data cache.
// Optional DCACHE_PERF_EN adds hit_count / miss_count outputs.
module data_cache
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int BLOCK_WIDTH   = 128,
  parameter int SETS          = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  data_cache_if.slave bus
`ifdef DCACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int IDX_W = index_w(SETS);
  localparam int TAG_W = tag_w(ADDRESS_WIDTH, SETS);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       index;
  logic [TAG_W-1:0]       cpu_tag, line_tag;
  logic [WORD_SEL_W-1:0]  word_sel;
  logic                   line_valid, line_dirty;
  logic [BLOCK_WIDTH-1:0] line_data;
  logic                   hit, fill_en, store_en;
  logic                   unused;

  assign index    = bus.cpu_addr[OFFSET_W +: IDX_W];
  assign cpu_tag  = bus.cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
  assign word_sel = bus.cpu_addr[2 +: WORD_SEL_W];
  assign unused   = ^bus.cpu_addr[1:0];
  assign hit      = line_valid && (line_tag == cpu_tag);

  dcache_line_store #(
    .SETS(SETS), .TAG_W(TAG_W), .BLOCK_WIDTH(BLOCK_WIDTH), .IDX_W(IDX_W)
  ) u_store (
    .clk       (clk),
    .rst_n     (rst_n),
    .index     (index),
    .rd_valid  (line_valid),
    .rd_dirty  (line_dirty),
    .rd_tag    (line_tag),
    .rd_data   (line_data),
    .fill_en   (fill_en),
    .fill_tag  (cpu_tag),
    .fill_data (bus.mem_rdata),
    .store_en  (store_en),
    .store_word(word_sel),
    .store_be  (bus.cpu_byte_en),
    .store_data(bus.cpu_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COMPARE;
    else        state <= state_nxt;
  end

  // Miss handling always runs to completion, even if the request drops.
  always_comb begin
    state_nxt     = state;
    fill_en       = 1'b0;
    store_en      = 1'b0;
    bus.mem_wr_en = 1'b0;
    bus.mem_addr  = {cpu_tag, index, {OFFSET_W{1'b0}}};
    case (state)
      COMPARE: begin
        if (bus.cpu_req) begin
          if (hit)                          store_en  = bus.cpu_we;
          else if (line_valid && line_dirty) state_nxt = WRITEBACK;
          else                              state_nxt = ALLOCATE;
        end
      end
      WRITEBACK: begin
        bus.mem_wr_en = 1'b1;
        bus.mem_addr  = {line_tag, index, {OFFSET_W{1'b0}}};
        state_nxt     = ALLOCATE;
      end
      ALLOCATE: begin
        fill_en   = 1'b1;
        state_nxt = COMPARE;
      end
      default: state_nxt = COMPARE;
    endcase
  end

  assign bus.mem_wdata = line_data;
  assign bus.cpu_rdata = line_data[word_sel*32 +: 32];
  assign bus.cpu_stall = bus.cpu_req && !(state == COMPARE && hit);

`ifdef DCACHE_PERF_EN
  // The access that caused a miss is counted once, as a miss, not again when served after refill.
  logic after_fill;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      after_fill <= 1'b0;
    end else begin
      after_fill <= (state == ALLOCATE);
      if (state == COMPARE && bus.cpu_req) begin
        if (!hit)            miss_count <= miss_count + 32'd1;
        else if (!after_fill) hit_count  <= hit_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_data_cache.sv
// Randomized self-checking bench for data_cache against an address-level memory/tag model.
module tb_data_cache;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  data_cache_if #(.ADDRESS_WIDTH(32), .BLOCK_WIDTH(128)) bus ();

`ifdef DCACHE_PERF_EN
  logic [31:0] hit_count, miss_count;
`endif

  data_cache #(.ADDRESS_WIDTH(32), .BLOCK_WIDTH(128), .SETS(256)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DCACHE_PERF_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  // data_mem: 16 KB of blocks, combinational read
  logic [127:0] mem_blk [1024];
  assign bus.mem_rdata = mem_blk[bus.mem_addr[13:4]];

  // Reference: architectural memory words plus which block each set holds
  logic [31:0] ref_w [4096];
  bit          r_valid [256];
  bit          r_dirty [256];
  int          r_tag   [256];
  int          exp_hits, exp_miss;

  int n_chk, n_pass;
  logic [31:0]  last_rdata, last_wb_addr;
  logic [127:0] last_wb_data;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      r_valid[i] = 0;
      r_dirty[i] = 0;
    end
    for (int a = 0; a < 4096; a++) ref_w[a] = mem_blk[a/4][(a%4)*32 +: 32];
    exp_hits = 0;
    exp_miss = 0;
  endtask

  task automatic chk_perf();
`ifdef DCACHE_PERF_EN
    chk("hit_count",  hit_count,  exp_hits);
    chk("miss_count", miss_count, exp_miss);
`endif
  endtask

  task automatic access(input bit we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    int idx, tg, cyc, wbs, wi;
    bit hit, dvict;
    logic [31:0]  vict;
    logic [127:0] vblk;
    idx   = int'(addr[11:4]);
    tg    = int'(addr[13:12]);
    hit   = r_valid[idx] && (r_tag[idx] == tg);
    dvict = !hit && r_valid[idx] && r_dirty[idx];
    vict  = (r_tag[idx] << 12) | (idx << 4);
    for (int w = 0; w < 4; w++) vblk[w*32 +: 32] = ref_w[(vict >> 2) + w];
    @(negedge clk);
    bus.cpu_req     = 1'b1;
    bus.cpu_we      = we;
    bus.cpu_addr    = addr;
    bus.cpu_byte_en = be;
    bus.cpu_wdata   = wd;
    #1;
    chk("mem_addr_cmp", bus.mem_addr, {addr[31:4], 4'h0});
    cyc = 0;
    wbs = 0;
    while (bus.cpu_stall && cyc < 8) begin
      if (bus.mem_wr_en) begin
        wbs++;
        chk("wb_addr", bus.mem_addr, vict);
        chk("wb_data", bus.mem_wdata, vblk);
        last_wb_addr = bus.mem_addr;
        last_wb_data = bus.mem_wdata;
        mem_blk[bus.mem_addr[13:4]] = bus.mem_wdata;
      end else if (cyc > 0) begin
        chk("alloc_addr", bus.mem_addr, {addr[31:4], 4'h0});
      end
      cyc++;
      @(negedge clk);
      #1;
    end
    // The miss-detect cycle also raises stall; the penalty is the WRITEBACK/ALLOCATE cycles.
    chk("penalty", (cyc == 0) ? 0 : cyc - 1, hit ? 0 : (dvict ? 2 : 1));
    chk("wb_count", wbs, dvict);
    chk("wr_idle", bus.mem_wr_en, 1'b0);
    wi = int'(addr[13:2]);
    if (!we) chk("rdata", bus.cpu_rdata, ref_w[wi]);
    last_rdata = bus.cpu_rdata;
    exp_hits += hit ? 1 : 0;
    exp_miss += hit ? 0 : 1;
    if (!hit) r_dirty[idx] = 0;
    r_valid[idx] = 1;
    r_tag[idx]   = tg;
    if (we) begin
      r_dirty[idx] = 1;
      for (int b = 0; b < 4; b++) if (be[b]) ref_w[wi][b*8 +: 8] = wd[b*8 +: 8];
    end
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
  endtask

  // Requests must hold address/command steady while stalled
  logic [36:0] p_cmd;
  bit          p_stall;
  always @(negedge clk) begin
    #2;
    if (p_stall && bus.cpu_req)
      chk("proto", {bus.cpu_we, bus.cpu_byte_en, bus.cpu_addr}, p_cmd);
    p_stall = bus.cpu_stall && rst_n;
    p_cmd   = {bus.cpu_we, bus.cpu_byte_en, bus.cpu_addr};
  end

  initial begin
    logic [31:0] a, orig;
    n_chk = 0;
    n_pass = 0;
    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_byte_en = 0; bus.cpu_wdata = 0;
    for (int b = 0; b < 1024; b++)
      for (int w = 0; w < 4; w++) mem_blk[b][w*32 +: 32] = (b * 4 + w) * 32'h9E3779B1 + 32'h1234;
    mem_blk[16][31:0] = 32'h11223344;
    model_reset();

    repeat (2) @(negedge clk);
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_wr_en", bus.mem_wr_en, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_perf();

    // first load misses clean, repeat hits
    access(0, 32'h100, 4'h0, 0);
    chk("ld100", last_rdata, 32'h11223344);
    chk_perf();
    access(0, 32'h100, 4'h0, 0);
    chk_perf();

    // byte-enabled store then reload
    access(1, 32'h100, 4'b0101, 32'hAABBCCDD);
    access(0, 32'h100, 4'h0, 0);
    chk("merge", last_rdata, 32'h11BB33DD);

    // dirty conflict miss
    access(0, 32'h1100, 4'h0, 0);
    chk("wb_victim", last_wb_addr, 32'h100);
    chk("wb_word0", last_wb_data[31:0], 32'h11BB33DD);

    // clean conflict miss
    access(0, 32'h200, 4'h0, 0);
    access(0, 32'h1200, 4'h0, 0);

    // four words of one line
    for (int w = 0; w < 4; w++) begin
      a = 32'h300 + w * 4;
      access(0, a, 4'h0, 0);
      chk("line_word", last_rdata, mem_blk[48][w*32 +: 32]);
    end

    // store-only miss with byte_en=0 still dirties
    access(1, 32'h500, 4'h0, 32'hFFFFFFFF);
    access(0, 32'h1500, 4'h0, 0);

    // reset in the middle of a writeback
    orig = mem_blk[64][31:0];
    access(1, 32'h400, 4'hF, 32'hDEADBEEF);
    @(negedge clk);
    bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 32'h1400;
    #1;
    chk("pre_wb_stall", bus.cpu_stall, 1'b1);
    @(posedge clk);
    #1;
    chk("in_wb", bus.mem_wr_en, 1'b1);
    #1;
    rst_n = 1'b0;
    bus.cpu_req = 0;
    #1;
    chk("rstwb_stall", bus.cpu_stall, 1'b0);
    chk("rstwb_wr_en", bus.mem_wr_en, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(0, 32'h400, 4'h0, 0);
    chk("lost_store", last_rdata, orig);
    chk_perf();

    // random traffic concentrated on a few sets to force conflicts
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) a = {18'h0, $urandom_range(0, 4095) * 4};
      else a = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 3) << 2);
      access($urandom_range(0, 1), a, 4'($urandom_range(0, 15)), $urandom);
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end
    chk_perf();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
